// File: rtl/square_requester.sv
// Launches one square-unit operation per accepted operand and returns the captured result.
// Latency: accept to out_valid_out is 5 cycles with the standard unit; supervised by a timeout.
// Backpressure: in_ready_out only in IDLE; RESULT holds until out_ready_in, blocking new operands.
module square_requester #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int TIMEOUT      = 15,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    in_valid_in,
    input  logic [DATA_WIDTH-1:0]   in_data_in,
    output logic                    in_ready_out,
    output logic                    start_out,
    output logic [DATA_WIDTH-1:0]   operand_out,
    input  logic                    busy_in,
    input  logic                    done_in,
    input  logic [RESULT_WIDTH-1:0] result_in,
    output logic                    out_valid_out,
    output logic [RESULT_WIDTH-1:0] out_data_out,
    input  logic                    out_ready_in,
    input  logic                    clear_in,
    output logic                    err_pulse_out,
    output logic                    err_sticky_out,
    output logic [COUNT_WIDTH-1:0]  ops_count_out
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t                  state, state_nxt;
    logic [TW-1:0]           tcnt, tcnt_nxt;
    logic [DATA_WIDTH-1:0]   operand_q;
    logic [RESULT_WIDTH-1:0] result_q;
    logic [COUNT_WIDTH-1:0]  ops_q;
    logic                    err_pulse_q, err_sticky_q;
    logic                    accept, capture, timeout, deliver;

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid_in) begin
                    accept    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                tcnt_nxt  = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_in) begin
                    tcnt_nxt  = '0;
                    state_nxt = WAIT_DONE;
                end else if (done_in) begin
                    // Busy pulse was too short to observe; the result is already here.
                    capture   = 1'b1;
                    state_nxt = RESULT;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    tcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (done_in) begin
                    capture   = 1'b1;
                    state_nxt = RESULT;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    tcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            RESULT: begin
                if (out_ready_in) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            tcnt         <= '0;
            operand_q    <= '0;
            result_q     <= '0;
            ops_q        <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            tcnt        <= tcnt_nxt;
            err_pulse_q <= timeout;
            // The unit samples the operand late, so it only moves on a new accept.
            if (accept)
                operand_q <= in_data_in;
            if (capture)
                result_q <= result_in;
            if (deliver)
                ops_q <= ops_q + COUNT_WIDTH'(1);
            if (timeout)
                err_sticky_q <= 1'b1;
            else if (clear_in)
                err_sticky_q <= 1'b0;
        end
    end

    assign in_ready_out   = (state == IDLE);
    assign out_valid_out  = (state == RESULT);
    assign start_out      = (state == LAUNCH);
    assign operand_out    = operand_q;
    assign out_data_out   = result_q;
    assign err_pulse_out  = err_pulse_q;
    assign err_sticky_out = err_sticky_q;
    assign ops_count_out  = ops_q;

endmodule

// File: tb/tb_square_requester.sv
// Bench for square_requester: vector table, hand-written corner sequences and a random run
// against a scoreboard of squares, with a behavioural square unit that samples the operand late.
module tb_square_requester;

    localparam int DW = 8;
    localparam int RW = 16;
    localparam int CW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          in_valid_in = 1'b0;
    logic [DW-1:0] in_data_in = '0;
    logic          in_ready_out;
    logic          start_out;
    logic [DW-1:0] operand_out;
    logic          busy_in = 1'b0;
    logic          done_in = 1'b0;
    logic [RW-1:0] result_in = '0;
    logic          out_valid_out;
    logic [RW-1:0] out_data_out;
    logic          out_ready_in = 1'b0;
    logic          clear_in = 1'b0;
    logic          err_pulse_out;
    logic          err_sticky_out;
    logic [CW-1:0] ops_count_out;

    logic          in_ready2, start2, out_valid2, err_pulse2, err_sticky2;
    logic [DW-1:0] operand2;
    logic [RW-1:0] out_data2;
    logic [1:0]    ops_count2;

    square_requester #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TIMEOUT(15), .COUNT_WIDTH(CW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .in_valid_in(in_valid_in), .in_data_in(in_data_in), .in_ready_out(in_ready_out),
        .start_out(start_out), .operand_out(operand_out),
        .busy_in(busy_in), .done_in(done_in), .result_in(result_in),
        .out_valid_out(out_valid_out), .out_data_out(out_data_out), .out_ready_in(out_ready_in),
        .clear_in(clear_in), .err_pulse_out(err_pulse_out), .err_sticky_out(err_sticky_out),
        .ops_count_out(ops_count_out)
    );

    square_requester #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TIMEOUT(15), .COUNT_WIDTH(2)) dut_c2 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .in_valid_in(in_valid_in), .in_data_in(in_data_in), .in_ready_out(in_ready2),
        .start_out(start2), .operand_out(operand2),
        .busy_in(busy_in), .done_in(done_in), .result_in(result_in),
        .out_valid_out(out_valid2), .out_data_out(out_data2), .out_ready_in(out_ready_in),
        .clear_in(clear_in), .err_pulse_out(err_pulse2), .err_sticky_out(err_sticky2),
        .ops_count_out(ops_count2)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Behavioural square unit: busy for busy_len cycles, then gap idle cycles, then a done pulse.
    logic          unit_en = 1'b1;
    int            busy_len = 2;
    int            gap = 0;
    int            ph = -1;
    int            bl = 0;
    int            gp = 0;
    logic [RW-1:0] late_op;

    always begin
        @(posedge clk_in);
        if (!rst_n_in)
            ph = -1;
        else if (ph >= 0)
            ph++;
        else if (unit_en && start_out) begin
            ph = 0;
            bl = busy_len;
            gp = gap;
        end
        late_op = {8'b0, operand_out};
        #1;
        busy_in   = rst_n_in && ph >= 0 && ph < bl;
        done_in   = rst_n_in && ph >= 0 && ph == bl + gp;
        result_in = done_in ? late_op * late_op : '0;
        if (done_in)
            ph = -1;
    end

    // Runs one operand up to the first out_valid cycle; lat counts cycles from accept.
    task automatic run_op(input logic [DW-1:0] op, input int b, input int g,
                          output logic [RW-1:0] res, output int lat,
                          output int starts, output int unstable);
        int n;
        busy_len = b;
        gap = g;
        in_data_in = op;
        in_valid_in = 1'b1;
        n = 0;
        while (!in_ready_out && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid_in = 1'b0;
        lat = 1;
        starts = 0;
        unstable = 0;
        while (!out_valid_out && lat < 60) begin
            if (start_out) starts++;
            if ((busy_in || in_ready_out) && operand_out !== op) unstable++;
            if (in_ready_out) unstable++;
            tick();
            lat++;
        end
        if (lat >= 60) chk("op_timeout_bound", 32'(lat), 32'(0));
        res = out_data_out;
    endtask

    typedef struct {
        logic [DW-1:0] op;
        int            b;
        int            g;
        logic [RW-1:0] exp_res;
        int            exp_lat;
    } vec_t;

    initial begin
        vec_t          vt[6];
        logic [RW-1:0] res, d, t;
        logic [DW-1:0] held;
        logic [RW-1:0] exp_q[$];
        logic [RW-1:0] got[2];
        int            lat, starts, unstable, bad, n, acc, ngot;
        int            exp_cnt, acc_n, start_n, stab_err;
        logic          deliv;

        vt[0] = '{8'd12,  2, 0, 16'd144,   5};
        vt[1] = '{8'd255, 2, 0, 16'd65025, 5};
        vt[2] = '{8'd0,   2, 0, 16'd0,     5};
        vt[3] = '{8'd200, 0, 0, 16'd40000, 3};
        vt[4] = '{8'd9,   1, 2, 16'd81,    6};
        vt[5] = '{8'd100, 3, 1, 16'd10000, 7};

        tick();
        tick();
        chk("rst_in_ready", in_ready_out, 1);
        chk("rst_out_valid", out_valid_out, 0);
        chk("rst_start", start_out, 0);
        chk("rst_operand", operand_out, 0);
        chk("rst_out_data", out_data_out, 0);
        chk("rst_err", {err_pulse_out, err_sticky_out}, 0);
        chk("rst_count", ops_count_out, 0);
        #2 rst_n_in = 1'b1;
        tick();

        out_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].op, vt[i].b, vt[i].g, res, lat, starts, unstable);
            chk("vec_result", res, vt[i].exp_res);
            chk("vec_latency", 32'(lat), 32'(vt[i].exp_lat));
            chk("vec_starts", 32'(starts), 1);
            chk("vec_hold", 32'(unstable), 0);
            chk("vec_result_c2", {out_valid2, out_data2}, {1'b1, vt[i].exp_res});
            tick();
            chk("vec_count", ops_count_out, 32'(i + 1));
            chk("vec_count_c2", ops_count2, 32'((i + 1) % 4));
        end

        // Two operands back to back with in_valid_in held high.
        busy_len = 2;
        gap = 0;
        in_valid_in = 1'b1;
        in_data_in = 8'd255;
        acc = 0;
        ngot = 0;
        bad = 0;
        held = 8'd255;
        n = 0;
        while (ngot < 2 && n < 40) begin
            deliv = 1'b0;
            if (in_valid_in && in_ready_out) acc++;
            if (!in_ready_out && acc > 0 && busy_in && operand_out !== held) bad++;
            if (busy_in && in_ready_out) bad++;
            if (out_valid_out && out_ready_in) begin
                got[ngot] = out_data_out;
                ngot++;
            end
            tick();
            n++;
            if (acc == 1) begin
                in_data_in = 8'd0;
                if (in_ready_out) held = 8'd0;
            end
            if (acc == 2) in_valid_in = 1'b0;
        end
        chk("b2b_count", 32'(ngot), 2);
        chk("b2b_first", got[0], 16'd65025);
        chk("b2b_second", got[1], 16'd0);
        chk("b2b_handshake", 32'(bad), 0);
        chk("b2b_ops", ops_count_out, 8);

        // Result held while downstream stalls.
        out_ready_in = 1'b0;
        run_op(8'd42, 2, 0, res, lat, starts, unstable);
        d = out_data_out;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid_out || out_data_out !== d || in_ready_out || start_out) bad++;
        end
        chk("stall_data", d, 16'd1764);
        chk("stall_hold", 32'(bad), 0);
        chk("stall_count", ops_count_out, 8);
        out_ready_in = 1'b1;
        tick();
        chk("stall_release", ops_count_out, 9);
        tick();
        chk("stall_once", ops_count_out, 9);

        // Silent unit: timeout after 15 WAIT_BUSY cycles.
        unit_en = 1'b0;
        in_data_in = 8'd50;
        in_valid_in = 1'b1;
        tick();
        in_valid_in = 1'b0;
        n = 1;
        while (!err_pulse_out && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycle", 32'(n), 17);
        chk("to_state", {err_sticky_out, in_ready_out, out_valid_out}, 3'b110);
        tick();
        chk("to_pulse_once", {err_pulse_out, err_sticky_out}, 2'b01);
        chk("to_count", ops_count_out, 9);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("to_clear", err_sticky_out, 0);
        unit_en = 1'b1;
        run_op(8'd3, 2, 0, res, lat, starts, unstable);
        chk("to_next", res, 16'd9);
        tick();
        chk("to_next_count", ops_count_out, 10);

        // Asynchronous reset while in WAIT_DONE.
        busy_len = 2;
        gap = 3;
        in_data_in = 8'd77;
        in_valid_in = 1'b1;
        tick();
        in_valid_in = 1'b0;
        tick();
        tick();
        #3 rst_n_in = 1'b0;
        #1;
        chk("arst_outputs", {start_out, out_valid_out, err_pulse_out, err_sticky_out}, 0);
        chk("arst_data", {operand_out, out_data_out}, 0);
        chk("arst_count", ops_count_out, 0);
        tick();
        tick();
        #2 rst_n_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("arst_no_result", {out_valid_out, err_sticky_out, in_ready_out}, 3'b001);
        chk("arst_count_after", ops_count_out, 0);
        run_op(8'd7, 2, 0, res, lat, starts, unstable);
        chk("arst_next", res, 16'd49);
        tick();
        chk("arst_next_count", ops_count_out, 1);

        // Random traffic against a queue of expected squares.
        exp_cnt = 1;
        acc_n = 0;
        start_n = 0;
        stab_err = 0;
        held = '0;
        for (int c = 0; c < 3040; c++) begin
            deliv = 1'b0;
            if (c < 3000) begin
                in_valid_in = 1'($urandom_range(0, 1));
                in_data_in = 8'($urandom);
                out_ready_in = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid_in = 1'b0;
                out_ready_in = 1'b1;
            end
            if (in_valid_in && in_ready_out) begin
                busy_len = $urandom_range(0, 3);
                gap = $urandom_range(0, 4);
                t = {8'b0, in_data_in};
                exp_q.push_back(t * t);
                held = in_data_in;
                acc_n++;
            end
            if (start_out) start_n++;
            if (busy_in && operand_out !== held) stab_err++;
            if (out_valid_out && out_ready_in) begin
                if (exp_q.size() == 0) chk("rnd_unexpected", out_data_out, 0);
                else chk("rnd_data", out_data_out, exp_q.pop_front());
                exp_cnt = (exp_cnt + 1) % 65536;
                deliv = 1'b1;
            end
            tick();
            if (deliv) chk("rnd_count", ops_count_out, 32'(exp_cnt));
        end
        chk("rnd_drained", 32'(exp_q.size()), 0);
        chk("rnd_starts", 32'(start_n), 32'(acc_n));
        chk("rnd_operand_stable", 32'(stab_err), 0);
        chk("rnd_no_error", err_sticky_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
